// File: rtl/cia_bus_sequencer.sv
// cia_bus_sequencer
//   Generates the Phi 2 strobe pulses for the 8520 CIA and arbitrates its
//   register bus between two requesters (floppy FSM, host/debug port) and an
//   automatic ICR read that services the CIA interrupt. One register access
//   is performed per Phi 2 period.
//
// Ports
//   clk, res_n                 clock, asynchronous active-low reset
//   phi2_p / phi2_n            one-cycle pulses at Phi 2 rise / fall
//   reqN_valid/rw/rs/wdata     requester N access (N=0,1), held until reqN_done
//   reqN_done                  one-cycle completion pulse for requester N
//   rdata                      read data, valid while a reqN_done is high
//   irq_auto_en                enables automatic ICR service
//   icr_valid / icr_data       completion pulse and captured ICR value
//   cia_cs_n/rw/rs/wdata       CIA bus drive
//   cia_rdata, cia_irq_n       CIA data out and interrupt (synchronous to clk)
module cia_bus_sequencer #(
   parameter int PHI_DIV = 8
) (
   input  logic       clk,
   input  logic       res_n,
   output logic       phi2_p,
   output logic       phi2_n,
   input  logic       req0_valid,
   input  logic       req0_rw,
   input  logic [3:0] req0_rs,
   input  logic [7:0] req0_wdata,
   output logic       req0_done,
   input  logic       req1_valid,
   input  logic       req1_rw,
   input  logic [3:0] req1_rs,
   input  logic [7:0] req1_wdata,
   output logic       req1_done,
   output logic [7:0] rdata,
   input  logic       irq_auto_en,
   output logic       icr_valid,
   output logic [7:0] icr_data,
   output logic       cia_cs_n,
   output logic       cia_rw,
   output logic [3:0] cia_rs,
   output logic [7:0] cia_wdata,
   input  logic [7:0] cia_rdata,
   input  logic       cia_irq_n
);

   localparam int PH_W = $clog2(PHI_DIV);
   localparam logic [PH_W-1:0] PH_LAST     = PH_W'(PHI_DIV - 1);
   localparam logic [PH_W-1:0] PH_FALL_PRE = PH_W'(PHI_DIV / 2 - 1);
   localparam logic [PH_W-1:0] PH_REL      = PH_W'(PHI_DIV / 2);
   localparam logic [PH_W-1:0] PH_CMP      = PH_W'(PHI_DIV / 2 + 1);
   localparam logic [3:0]      RS_ICR      = 4'hD;

   typedef enum logic [1:0] {SRC_REQ0, SRC_REQ1, SRC_IRQ, SRC_NONE} src_e;

   logic [PH_W-1:0] ph;
   logic            last;
   logic            lockout;

   // Stage p0: access in flight between grant and completion
   logic            vld_p0;
   src_e            own_p0;
   logic            rw_p0;

   logic            v0, v1, irq_win;
   src_e            gnt_src;
   logic            gnt_rw;
   logic [3:0]      gnt_rs;
   logic [7:0]      gnt_wdata;

   // A requester whose access is still in flight is not eligible; this only
   // matters when completion and decision share an edge (PHI_DIV=4).
   assign v0      = req0_valid & ~(vld_p0 & (own_p0 == SRC_REQ0));
   assign v1      = req1_valid & ~(vld_p0 & (own_p0 == SRC_REQ1));
   assign irq_win = irq_auto_en & ~cia_irq_n & ~lockout;

   always_comb begin
      gnt_src   = SRC_NONE;
      gnt_rw    = 1'b1;
      gnt_rs    = 4'h0;
      gnt_wdata = 8'h00;
      if (irq_win) begin
         gnt_src = SRC_IRQ;
         gnt_rs  = RS_ICR;
      end else if (v0 && (!v1 || last)) begin
         gnt_src   = SRC_REQ0;
         gnt_rw    = req0_rw;
         gnt_rs    = req0_rs;
         gnt_wdata = req0_rw ? 8'h00 : req0_wdata;
      end else if (v1) begin
         gnt_src   = SRC_REQ1;
         gnt_rw    = req1_rw;
         gnt_rs    = req1_rs;
         gnt_wdata = req1_rw ? 8'h00 : req1_wdata;
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         ph        <= '0;
         last      <= 1'b1;
         lockout   <= 1'b0;
         phi2_p    <= 1'b0;
         phi2_n    <= 1'b0;
         req0_done <= 1'b0;
         req1_done <= 1'b0;
         icr_valid <= 1'b0;
         rdata     <= 8'h00;
         icr_data  <= 8'h00;
         cia_cs_n  <= 1'b1;
         cia_rw    <= 1'b1;
         cia_rs    <= 4'h0;
         cia_wdata <= 8'h00;
         vld_p0    <= 1'b0;
         own_p0    <= SRC_NONE;
         rw_p0     <= 1'b1;
      end else begin
         // Strobes are registered so they line up with the ph value they mark
         phi2_p    <= (ph == PH_LAST);
         phi2_n    <= (ph == PH_FALL_PRE);
         ph        <= (ph == PH_LAST) ? '0 : ph + 1'b1;
         req0_done <= 1'b0;
         req1_done <= 1'b0;
         icr_valid <= 1'b0;

         if (ph == PH_REL) begin
            cia_cs_n  <= 1'b1;
            cia_rw    <= 1'b1;
            cia_rs    <= 4'h0;
            cia_wdata <= 8'h00;
         end

         // Stage p1: completion, one cycle after the bus returns to idle
         if (ph == PH_CMP && vld_p0) begin
            vld_p0 <= 1'b0;
            unique case (own_p0)
               SRC_REQ0: begin
                  req0_done <= 1'b1;
                  rdata     <= rw_p0 ? cia_rdata : 8'h00;
               end
               SRC_REQ1: begin
                  req1_done <= 1'b1;
                  rdata     <= rw_p0 ? cia_rdata : 8'h00;
               end
               SRC_IRQ: begin
                  icr_valid <= 1'b1;
                  icr_data  <= cia_rdata;
               end
               default: ;
            endcase
         end

         // Decision edge; placed last so a new grant wins over completion
         // bookkeeping on the same edge.
         if (ph == PH_LAST) begin
            // The CIA keeps irq_n low until the phi2_p after an ICR read, so
            // the following decision must ignore it.
            lockout <= (gnt_src != SRC_NONE) && gnt_rw && (gnt_rs == RS_ICR);
            if (gnt_src != SRC_NONE) begin
               cia_cs_n  <= 1'b0;
               cia_rw    <= gnt_rw;
               cia_rs    <= gnt_rs;
               cia_wdata <= gnt_wdata;
               vld_p0    <= 1'b1;
               own_p0    <= gnt_src;
               rw_p0     <= gnt_rw;
               if (gnt_src != SRC_IRQ)
                  last <= (gnt_src == SRC_REQ1);
            end
         end
      end
   end

endmodule
